// File: rtl/button_gesture.sv
// Classifies debounced button strobes into single-cycle gesture events:
// click, double click, long press and auto-repeat while held.
module button_gesture #(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int CNT_W       = 24,
  parameter int LONG_CYC    = 6_000_000,
  parameter int DBL_GAP_CYC = 3_000_000,
  parameter int REPEAT_CYC  = 1_200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic rising,
  input  logic falling,
  output logic held,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, DRAIN, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press_ev, release_ev;

  // Coincident strobes cancel each other out.
  always_comb begin
    press_ev   = ACTIVE_LOW ? (falling & ~rising) : (rising & ~falling);
    release_ev = ACTIVE_LOW ? (rising & ~falling) : (falling & ~rising);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      held         <= 1'b0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
    end else begin
      held         <= ACTIVE_LOW ? ~level : level;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (press_ev) state <= PRESS1;
        end
        PRESS1: begin
          if (release_ev) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= LONG;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (press_ev) begin
            double_click <= 1'b1;
            state        <= DRAIN;
            cnt          <= '0;
          end else if (cnt == GAP_LAST) begin
            // Gap expired without a second press: only now is it a click.
            click <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          cnt <= '0;
          if (release_ev) state <= IDLE;
        end
        LONG: begin
          if (release_ev) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            repeat_tick <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture: timestamp-based gesture model checked every
// cycle, plus hand-computed pulse timings per scenario.
module tb_button_gesture;
  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int REP  = 5;

  localparam int M_IDLE = 0, M_DOWN = 1, M_GAP = 2, M_DRAIN = 3, M_LONG = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic level = 1'b0, rising = 1'b0, falling = 1'b0;
  logic held, click, double_click, long_press, repeat_tick;

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_gesture #(
    .ACTIVE_LOW(1'b1), .CNT_W(24),
    .LONG_CYC(LONG), .DBL_GAP_CYC(GAP), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .rising(rising), .falling(falling),
    .held(held), .click(click), .double_click(double_click),
    .long_press(long_press), .repeat_tick(repeat_tick)
  );

  // Model: gesture phase plus the cycle it was entered; timeouts are elapsed-time
  // comparisons against that timestamp.
  int   mode, t0;
  logic p_ev, r_ev;
  logic e_held, e_click, e_dbl, e_long, e_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_IDLE; t0 = 0;
      {e_held, e_click, e_dbl, e_long, e_rep} = '0;
    end else begin
      p_ev = falling & ~rising;
      r_ev = rising & ~falling;
      {e_click, e_dbl, e_long, e_rep} = '0;
      e_held = ~level;
      case (mode)
        M_IDLE:  if (p_ev) begin mode = M_DOWN; t0 = cyc; end
        M_DOWN:  if (r_ev) begin mode = M_GAP; t0 = cyc; end
                 else if (cyc - t0 == LONG) begin e_long = 1; mode = M_LONG; t0 = cyc; end
        M_GAP:   if (p_ev) begin e_dbl = 1; mode = M_DRAIN; end
                 else if (cyc - t0 == GAP) begin e_click = 1; mode = M_IDLE; end
        M_DRAIN: if (r_ev) mode = M_IDLE;
        M_LONG:  if (r_ev) mode = M_IDLE;
                 else if ((cyc - t0) % REP == 0) e_rep = 1;
        default: mode = M_IDLE;
      endcase
    end
  end

  int n_click = 0, n_dbl = 0, n_long = 0, n_rep = 0;
  int click_at = 0, dbl_at = 0, long_at = 0, rep_at = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic step();
    logic [4:0] a, e;
    @(negedge clk);
    a = {held, click, double_click, long_press, repeat_tick};
    e = {e_held, e_click, e_dbl, e_long, e_rep};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cmp cyc=%0d actual=%b expected=%b (held,click,dbl,long,rep)", cyc, a, e);
    end
    checks++;
    if ($countones(a[3:0]) > 1) begin
      errors++;
      $display("FAIL onehot cyc=%0d actual=%b expected=at most one event", cyc, a[3:0]);
    end
    if (click)        begin n_click++; click_at = cyc; end
    if (double_click) begin n_dbl++;   dbl_at   = cyc; end
    if (long_press)   begin n_long++;  long_at  = cyc; end
    if (repeat_tick)  begin n_rep++;   rep_at   = cyc; end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) step();
  endtask

  task automatic strobe(input logic r, input logic f, input logic lvl);
    level = lvl; rising = r; falling = f;
    step();
    rising = 1'b0; falling = 1'b0;
  endtask

  int p, rl, bc, bd, bl, br;

  task automatic snap();
    bc = n_click; bd = n_dbl; bl = n_long; br = n_rep;
  endtask

  initial begin
    // Test 5: button pressed (level 0) through reset.
    wait_cyc(2);
    chk("reset_held", int'(held), 0);
    chk("reset_events", int'({click, double_click, long_press, repeat_tick}), 0);
    rst_n = 1'b1;
    wait_cyc(3);
    chk("held_after_reset", int'(held), 1);
    snap();
    wait_cyc(LONG + 5);
    strobe(1, 0, 1);
    wait_cyc(GAP + 5);
    chk("t5_no_events", n_click - bc + n_dbl - bd + n_long - bl + n_rep - br, 0);
    chk("t5_held_released", int'(held), 0);

    // Test 2: short press then no second press -> click.
    snap();
    strobe(0, 1, 0);
    wait_cyc(4);
    rl = cyc;
    strobe(1, 0, 1);
    wait_cyc(15);
    chk("t2_click_count", n_click - bc, 1);
    chk("t2_click_latency", click_at - rl, 11);
    chk("t2_other", n_dbl - bd + n_long - bl + n_rep - br, 0);

    // Test 3: second press 4 cycles after release -> double_click.
    snap();
    strobe(0, 1, 0);
    wait_cyc(4);
    rl = cyc;
    strobe(1, 0, 1);
    wait_cyc(3);
    strobe(0, 1, 0);
    chk("t3_dbl_now", int'(double_click), 1);
    chk("t3_dbl_latency", dbl_at - rl, 5);
    wait_cyc(2);
    strobe(1, 0, 1);
    wait_cyc(15);
    chk("t3_dbl_count", n_dbl - bd, 1);
    chk("t3_no_click", n_click - bc, 0);

    // Test 4: hold 32 cycles -> long press and two repeats.
    snap();
    p = cyc;
    strobe(0, 1, 0);
    wait_cyc(31);
    strobe(1, 0, 1);
    wait_cyc(15);
    chk("t4_long_count", n_long - bl, 1);
    chk("t4_long_at", long_at - p, 21);
    chk("t4_rep_count", n_rep - br, 2);
    chk("t4_last_rep_at", rep_at - p, 31);
    chk("t4_no_click", n_click - bc + n_dbl - bd, 0);

    // Test 6: coincident strobes ignored; press exactly on gap timeout.
    snap();
    strobe(1, 1, 1);
    wait_cyc(LONG + 5);
    chk("t6_idle_both", n_click - bc + n_dbl - bd + n_long - bl + n_rep - br, 0);
    strobe(0, 1, 0);
    wait_cyc(4);
    rl = cyc;
    strobe(1, 0, 1);
    wait_cyc(2);
    strobe(1, 1, 1);
    wait_cyc(6);
    strobe(0, 1, 0);
    wait_cyc(2);
    strobe(1, 0, 1);
    wait_cyc(15);
    chk("t6_dbl_count", n_dbl - bd, 1);
    chk("t6_dbl_at", dbl_at - rl, 11);
    chk("t6_no_click", n_click - bc, 0);

    // Test 1: async reset in the middle of a press, no pulse afterwards.
    snap();
    strobe(0, 1, 0);
    wait_cyc(3);
    chk("t1_held_before", int'(held), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_zero", int'({held, click, double_click, long_press, repeat_tick}), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(LONG + 10);
    strobe(1, 0, 1);
    wait_cyc(GAP + 5);
    chk("t1_no_events", n_click - bc + n_dbl - bd + n_long - bl + n_rep - br, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
